// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for the core's load/store path: 64-bit-word RAM behind
// a request/response valid-ready pair, with RV64 size/sign handling and fixed wait latency.
module riscv_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q, wdata_q;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem [DEPTH_WORDS];

  logic [AW-1:0] word;
  logic [2:0]    lane;
  logic [5:0]    shamt;
  logic [7:0]    size_mask, be;
  logic [63:0]   old_word, new_word, st_data, ld_raw, ld_ext;
  logic          misaligned, out_of_range, illegal, fault, access, mem_we;

  assign word     = addr_q[3 +: AW];
  assign lane     = addr_q[2:0];
  assign shamt    = {lane, 3'b000};
  assign old_word = mem[word];

  // Range check on the full address; the word index alone would alias.
  assign out_of_range = |addr_q[63:3+AW];
  assign illegal      = we_q ? funct3_q[2] : (funct3_q == 3'b111);

  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (funct3_q[1:0])
      2'b00: begin misaligned = 1'b0;       size_mask = 8'h01; end
      2'b01: begin misaligned = lane[0];    size_mask = 8'h03; end
      2'b10: begin misaligned = |lane[1:0]; size_mask = 8'h0F; end
      default: begin misaligned = |lane;    size_mask = 8'hFF; end
    endcase
  end

  assign fault   = out_of_range | misaligned | illegal;
  assign access  = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign mem_we  = access && we_q && !fault;
  assign be      = size_mask << lane;
  assign st_data = wdata_q << shamt;
  assign ld_raw  = old_word >> shamt;

  always_comb begin
    new_word = old_word;
    for (int unsigned i = 0; i < 8; i++) begin
      if (be[i]) new_word[8*i +: 8] = st_data[8*i +: 8];
    end
  end

  always_comb begin
    ld_ext = '0;
    case (funct3_q)
      3'b000: ld_ext = {{56{ld_raw[7]}},  ld_raw[7:0]};
      3'b001: ld_ext = {{48{ld_raw[15]}}, ld_raw[15:0]};
      3'b010: ld_ext = {{32{ld_raw[31]}}, ld_raw[31:0]};
      3'b011: ld_ext = ld_raw;
      3'b100: ld_ext = {56'd0, ld_raw[7:0]};
      3'b101: ld_ext = {48'd0, ld_raw[15:0]};
      3'b110: ld_ext = {32'd0, ld_raw[31:0]};
      default: ld_ext = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_WAIT;
          cnt_d   = 4'(LATENCY);
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          err_d   = fault;
          rdata_d = (fault || we_q) ? '0 : ld_ext;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && req_valid) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
    end
  end

  // RAM has no reset; a reset forces IDLE asynchronously so a pending store never commits.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word] <= new_word;
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Randomized bench for riscv_dmem_responder: two instances (LATENCY 2 / 512 words and
// LATENCY 0 / 16 words) checked against a byte-addressed reference memory.
module tb_riscv_dmem_responder;

  localparam int unsigned LAT0 = 2, LAT1 = 0;
  localparam longint unsigned NB0 = 4096, NB1 = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0, req_ready, req_we = '0, rsp_valid, rsp_ready = '0, rsp_err, busy;
  logic [2:0]  req_funct3 [2];
  logic [63:0] req_addr [2], req_wdata [2], rsp_rdata [2];

  logic [7:0]  mb [2][4096];
  int          n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  riscv_dmem_responder #(.DEPTH_WORDS(512), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]));

  riscv_dmem_responder #(.DEPTH_WORDS(16), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte memory, size = 2^funct3[1:0], natural alignment, RV64 extension rules.
  task automatic model_access(input int d, input bit we, input logic [2:0] f3,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              output logic [63:0] rd, output bit err);
    longint unsigned nbytes;
    int unsigned size, base;
    nbytes = (d == 0) ? NB0 : NB1;
    size   = 1 << f3[1:0];
    rd     = '0;
    err    = (addr >= nbytes) || ((addr % size) != 0) || (we && f3 >= 3'd4) ||
             (!we && f3 == 3'b111);
    if (err) return;
    base = int'(addr[31:0]);
    if (we) begin
      for (int k = 0; k < int'(size); k++) mb[d][base + k] = wdata[8*k +: 8];
    end else begin
      for (int k = 0; k < int'(size); k++) rd[8*k +: 8] = mb[d][base + k];
      if (f3 < 3'd4 && size < 8 && rd[8*size - 1]) begin
        for (int k = int'(size); k < 8; k++) rd[8*k +: 8] = 8'hFF;
      end
    end
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic do_txn(input int d, input bit we, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata, input int hold, input logic [63:0] exp_rd,
                        input bit exp_err, output logic [63:0] obs_rd);
    int lat;
    int unsigned exp_lat;
    exp_lat = (d == 0) ? LAT0 + 1 : LAT1 + 1;
    obs_rd  = '0;
    check("req_ready_idle", 64'(req_ready[d]), 64'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
    req_addr[d] = addr; req_wdata[d] = wdata;
    rsp_ready[d] = (hold == 0);
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_funct3[d] = 3'($urandom);
    req_addr[d] = {$urandom, $urandom}; req_wdata[d] = {$urandom, $urandom};
    check("busy_after_accept", 64'(busy[d]), 64'd1);
    check("req_ready_after_accept", 64'(req_ready[d]), 64'd0);
    lat = 0;
    while (rsp_valid[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    if (lat >= 40) return;
    obs_rd = rsp_rdata[d];
    check("rdata", rsp_rdata[d], exp_rd);
    check("err", 64'(rsp_err[d]), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(rsp_valid[d]), 64'd1);
      check("stall_rdata", rsp_rdata[d], exp_rd);
      check("stall_req_ready", 64'(req_ready[d]), 64'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    check("valid_after_hs", 64'(rsp_valid[d]), 64'd0);
    check("busy_after_hs", 64'(busy[d]), 64'd0);
  endtask

  task automatic run(input int d, input bit we, input logic [2:0] f3, input logic [63:0] addr,
                     input logic [63:0] wdata, input int hold, output logic [63:0] obs);
    logic [63:0] e_rd;
    bit e_err;
    model_access(d, we, f3, addr, wdata, e_rd, e_err);
    do_txn(d, we, f3, addr, wdata, hold, e_rd, e_err, obs);
  endtask

  initial begin
    logic [63:0] obs, addr, e_rd;
    bit we, e_err;
    logic [2:0] f3;
    int d;
    for (int i = 0; i < 2; i++) begin
      req_funct3[i] = '0; req_addr[i] = '0; req_wdata[i] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready[0]), 64'd1);
    check("rst_busy", 64'(busy[0]), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check("rst_rdata", rsp_rdata[0], 64'd0);
    check("rst_err", 64'(rsp_err[0]), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Give every word in the tested region a known value.
    for (int dd = 0; dd < 2; dd++)
      for (int w = 0; w < 16; w++) run(dd, 1'b1, 3'b011, 64'(8 * w), {$urandom, $urandom}, 0, obs);

    run(0, 1'b1, 3'b011, 64'h10, 64'h8877665544332211, 0, obs);
    check("sd_rdata_zero", obs, 64'd0);
    run(0, 1'b0, 3'b011, 64'h10, 64'd0, 0, obs);
    check("ld_0x10", obs, 64'h8877665544332211);
    run(0, 1'b0, 3'b000, 64'h17, 64'd0, 0, obs);
    check("lb_0x17", obs, 64'hFFFFFFFFFFFFFF88);
    run(0, 1'b0, 3'b100, 64'h17, 64'd0, 0, obs);
    check("lbu_0x17", obs, 64'h88);
    run(0, 1'b1, 3'b001, 64'h12, 64'hABCD, 0, obs);
    run(0, 1'b0, 3'b010, 64'h10, 64'd0, 0, obs);
    check("lw_after_sh", obs, 64'hFFFFFFFFABCD2211);
    run(0, 1'b0, 3'b010, 64'h12, 64'd0, 0, obs);
    run(0, 1'b1, 3'b011, 64'h1000, 64'hDEADBEEFDEADBEEF, 0, obs);
    run(0, 1'b0, 3'b011, 64'h0, 64'd0, 0, obs);
    run(0, 1'b1, 3'b100, 64'h18, 64'h55, 0, obs);
    run(0, 1'b0, 3'b011, 64'h18, 64'd0, 0, obs);
    run(0, 1'b0, 3'b011, 64'h10, 64'd0, 5, obs);
    run(1, 1'b0, 3'b011, 64'h10, 64'd0, 0, obs);
    run(1, 1'b1, 3'b010, 64'h78, 64'h12345678, 0, obs);
    run(1, 1'b0, 3'b110, 64'h78, 64'd0, 0, obs);

    // Reset during WAIT of SD 0x20: the store must never land.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b011;
    req_addr[0] = 64'h20; req_wdata[0] = 64'hCAFEF00DCAFEF00D;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(rsp_valid[0]), 64'd0);
    check("midrst_busy", 64'(busy[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(0, 1'b0, 3'b011, 64'h20, 64'd0, 0, obs);

    for (int n = 0; n < 200; n++) begin
      d  = int'($urandom_range(0, 1));
      we = 1'($urandom);
      f3 = 3'($urandom);
      case ($urandom_range(0, 9))
        8:       addr = ((d == 0) ? NB0 : NB1) + 64'($urandom_range(0, 63));
        9:       addr = {1'b1, 31'($urandom), $urandom};
        default: addr = 64'($urandom_range(0, 127));
      endcase
      if ($urandom_range(0, 1) == 1) addr = addr & ~64'((1 << f3[1:0]) - 1);
      model_access(d, we, f3, addr, 64'd0, e_rd, e_err);
      if (we && !e_err) begin
        obs = {$urandom, $urandom};
        model_access(d, we, f3, addr, obs, e_rd, e_err);
        do_txn(d, we, f3, addr, obs, int'($urandom_range(0, 3)), e_rd, e_err, obs);
      end else begin
        do_txn(d, we, f3, addr, 64'd0, int'($urandom_range(0, 3)), e_rd, e_err, obs);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
